// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the RV32 multi-cycle control FSM: opcodes, ALU ops,
// state encodings, datapath select codes and the bundled control word.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] FUNC7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_control;
  } ctrl_t;

  function automatic logic branch_taken(input logic [2:0] func3,
                                        input logic       zero,
                                        input logic       lt);
    case (func3)
      3'b000:  return zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Single-port memory handshake between the control FSM (master) and memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU-op decode used in EXEC: opcode/func3/func7 -> 3-bit ALU op.
module multicycle_control_alu_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_op_e    alu_control
);

  always_comb begin
    // NOTE: default assigned first so every path drives the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (func3)
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b000:  alu_control = (func7 == FUNC7_SUB) ? ALU_SUB : ALU_ADD;
          default: alu_control = ALU_ADD;
        endcase
      end
      OP_BRANCH: alu_control = ALU_SUB;
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32 core (FETCH/DECODE/EXEC/MEM/WB/FAULT).
// Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes into FAULT instead of retiring them as NOPs.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic [6:0]           func7,
  input  logic                 zero,
  input  logic                 lt,
  multicycle_control_if.master mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic [2:0]           state,
  output logic                 instr_done,
  output logic [RET_CNT_W-1:0] ret_cnt,
  output logic                 fault
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;
  logic              mem_wait;
  ctrl_t             ctrl, ctrl_out;
  alu_op_e           dec_alu;

  multicycle_control_alu_op_decode u_alu_op_decode (
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .alu_control (dec_alu)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      ret_cnt <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    retire   = 1'b0;
    mem_wait = 1'b0;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_req     = 1'b1;
        ctrl.alu_src_a   = SRC_A_PC;
        ctrl.alu_src_b   = SRC_B_FOUR;
        ctrl.alu_control = ALU_ADD;
        if (mem.mem_ready) begin
          ctrl.ir_we  = 1'b1;
          ctrl.pc_we  = 1'b1;
          ctrl.pc_src = PC_SRC_SEQ;
          state_d     = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_a   = SRC_A_OLD_PC;
        ctrl.alu_src_b   = SRC_B_IMM;
        ctrl.alu_control = ALU_ADD;
        state_d          = S_EXEC;
      end

      S_EXEC: begin
        ctrl.alu_control = dec_alu;
        state_d          = S_FETCH;
        case (opcode)
          OP_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            state_d        = S_WB;
          end
          OP_I: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            state_d        = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            state_d        = S_MEM;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            if (branch_taken(func3, zero, lt)) begin
              ctrl.pc_we  = 1'b1;
              ctrl.pc_src = PC_SRC_BRANCH;
            end
            retire = 1'b1;
          end
          OP_JAL: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_BRANCH;
            ctrl.reg_we = 1'b1;
            ctrl.wb_sel = WB_SEL_LINK;
            retire      = 1'b1;
          end
          OP_JALR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.pc_we     = 1'b1;
            ctrl.pc_src    = PC_SRC_JALR;
            ctrl.reg_we    = 1'b1;
            ctrl.wb_sel    = WB_SEL_LINK;
            retire         = 1'b1;
          end
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_FAULT;
`else
            retire  = 1'b1;
`endif
          end
        endcase
      end

      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (opcode == OP_STORE);
        if (mem.mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else begin
          mem_wait = 1'b1;
        end
      end

      S_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.wb_sel = (opcode == OP_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_FETCH;
    endcase

    // The final unanswered cycle of a request abandons it instead of waiting forever.
    if (mem_wait && wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
      state_d = S_FAULT;
      retire  = 1'b0;
    end

    if (state_d != state_q) wait_d = '0;
    else if (mem_wait)      wait_d = wait_q + 1'b1;
    else                    wait_d = wait_q;
  end

  // Reset forces every control output low even while the state register still holds the old state.
  assign ctrl_out    = rst ? '0 : ctrl;
  assign mem.mem_req = ctrl_out.mem_req;
  assign mem.mem_we  = ctrl_out.mem_we;
  assign ir_we       = ctrl_out.ir_we;
  assign pc_we       = ctrl_out.pc_we;
  assign pc_src      = ctrl_out.pc_src;
  assign reg_we      = ctrl_out.reg_we;
  assign wb_sel      = ctrl_out.wb_sel;
  assign alu_src_a   = ctrl_out.alu_src_a;
  assign alu_src_b   = ctrl_out.alu_src_b;
  assign alu_control = ctrl_out.alu_control;
  assign state       = state_q;
  assign instr_done  = retire & ~rst;
  assign fault       = (state_q == S_FAULT) & ~rst;

endmodule
